// File: rtl/mem_resp_queue_pkg.sv
// Shared definitions for the memory response queue: load-op encoding,
// default sizing and the width of one recorded request.
package mem_resp_queue_pkg;

    localparam int LOAD_OP_W = 5;

    // One-hot bit positions inside load_op {w,b,bu,h,hu}; all-zero means store.
    localparam int OP_W  = 4;
    localparam int OP_B  = 3;
    localparam int OP_BU = 2;
    localparam int OP_H  = 1;
    localparam int OP_HU = 0;

    localparam int DEFAULT_DEPTH = 2;
    localparam int DEFAULT_TAG_W = 38;

    typedef logic [LOAD_OP_W-1:0] load_op_t;

    function automatic int req_bus_w(input int tag_w);
        return LOAD_OP_W + 2 + tag_w;
    endfunction

endpackage

// File: rtl/mem_resp_queue_load_extract.sv
// Combinational load data extraction: selects byte/half/word from a 32-bit
// read word by address offset and sign/zero extends it. Stores yield zero.
module mem_resp_queue_load_extract
    import mem_resp_queue_pkg::*;
(
    input  logic [LOAD_OP_W-1:0] load_op,
    input  logic [1:0]           off,
    input  logic [31:0]          rdata,
    output logic [31:0]          result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        result   = '0;
        if (load_op[OP_W]) begin
            result = rdata;
        end else if (load_op[OP_B]) begin
            result = {{24{byte_sel[7]}}, byte_sel};
        end else if (load_op[OP_BU]) begin
            result = {24'b0, byte_sel};
        end else if (load_op[OP_H]) begin
            result = {{16{half_sel[15]}}, half_sel};
        end else if (load_op[OP_HU]) begin
            result = {16'b0, half_sel};
        end
    end

endmodule

// File: rtl/mem_resp_queue.sv
// Outstanding data-sram request queue: records accepted requests, matches
// in-order data_ok responses, and retires extracted results to WB in order.
module mem_resp_queue
    import mem_resp_queue_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    parameter  int TAG_W = DEFAULT_TAG_W,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req_fire,
    input  logic [LOAD_OP_W-1:0] req_load_op,
    input  logic [1:0]           req_off,
    input  logic [TAG_W-1:0]     req_tag,
    input  logic                 data_ok,
    input  logic [31:0]          data_rdata,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_is_store,
    output logic                 q_full,
    output logic                 q_empty,
    output logic                 proto_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int REQ_W = req_bus_w(TAG_W);

    logic [REQ_W-1:0] req_mem   [DEPTH];
    logic [31:0]      rdata_mem [DEPTH];
    logic [DEPTH-1:0] done_q;
    logic [PTR_W-1:0] wr_ptr, resp_ptr, rd_ptr;
    logic [CNT_W-1:0] occ, discard_cnt;
    logic             proto_err_q;

    logic [CNT_W-1:0] done_cnt, undone_cnt, flush_owed, flush_discard;
    logic [CNT_W:0]   load_sum;
    logic             enq, deq, resp_take, discard_take, stray, flush_err, err_set;

    load_op_t         head_op;
    logic [1:0]       head_off;

    // A slot's done bit is set only while it holds a live entry, so the
    // number of live entries still owed a response is occ minus done bits.
    always_comb begin
        done_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            done_cnt = done_cnt + CNT_W'(done_q[i]);
        end
    end

    assign undone_cnt = occ - done_cnt;
    assign load_sum   = {1'b0, occ} + {1'b0, discard_cnt};
    assign q_full     = load_sum >= (CNT_W+1)'(DEPTH);
    assign q_empty    = (occ == '0) && (discard_cnt == '0);

    // WB handshake: a result transfers on any cycle where out_valid and
    // out_ready are both high; out_valid never drops until that happens
    // (except on flush/reset), and head payload holds stable meanwhile.
    assign out_valid = done_q[rd_ptr];
    assign enq       = req_fire & ~q_full & ~flush;
    assign deq       = out_valid & out_ready & ~flush;

    assign discard_take = data_ok & (discard_cnt != '0);
    assign resp_take    = data_ok & (discard_cnt == '0) & (undone_cnt != '0) & ~flush;
    assign stray        = data_ok & (discard_cnt == '0) & (undone_cnt == '0);

    // Everything still owed by the sram at flush time becomes discard work;
    // a coincident data_ok pays off one of those owed responses.
    assign flush_owed = discard_cnt + undone_cnt + CNT_W'(req_fire);
    always_comb begin
        flush_discard = flush_owed;
        flush_err     = 1'b0;
        if (data_ok) begin
            if (flush_owed == '0) begin
                flush_err = 1'b1;
            end else begin
                flush_discard = flush_owed - CNT_W'(1);
            end
        end
    end

    assign err_set = flush ? flush_err : ((req_fire & q_full) | stray);

    always_ff @(posedge clk) begin
        if (enq) begin
            req_mem[wr_ptr] <= {req_load_op, req_off, req_tag};
        end
        if (resp_take) begin
            rdata_mem[resp_ptr] <= data_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            resp_ptr    <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            discard_cnt <= '0;
            done_q      <= '0;
            proto_err_q <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            resp_ptr    <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            discard_cnt <= flush_discard;
            done_q      <= '0;
            proto_err_q <= proto_err_q | err_set;
        end else begin
            proto_err_q <= proto_err_q | err_set;
            if (enq) begin
                done_q[wr_ptr] <= 1'b0;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (resp_take) begin
                done_q[resp_ptr] <= 1'b1;
                resp_ptr         <= resp_ptr + PTR_W'(1);
            end else if (discard_take) begin
                discard_cnt <= discard_cnt - CNT_W'(1);
            end
            if (deq) begin
                done_q[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PTR_W'(1);
            end
            if (enq && !deq) begin
                occ <= occ + CNT_W'(1);
            end else if (deq && !enq) begin
                occ <= occ - CNT_W'(1);
            end
        end
    end

    assign {head_op, head_off, out_tag} = req_mem[rd_ptr];
    assign out_is_store = (head_op == '0);
    assign proto_err    = proto_err_q;

    mem_resp_queue_load_extract u_extract (
        .load_op (head_op),
        .off     (head_off),
        .rdata   (rdata_mem[rd_ptr]),
        .result  (out_result)
    );

endmodule

// File: tb/tb_mem_resp_queue.sv
// Self-checking bench for mem_resp_queue: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_mem_resp_queue;

    localparam int DEPTH = 2;
    localparam int TAG_W = 38;

    localparam logic [4:0] LD_W  = 5'b10000;
    localparam logic [4:0] LD_B  = 5'b01000;
    localparam logic [4:0] LD_BU = 5'b00100;
    localparam logic [4:0] LD_H  = 5'b00010;
    localparam logic [4:0] LD_HU = 5'b00001;
    localparam logic [4:0] ST    = 5'b00000;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             req_fire = 1'b0;
    logic [4:0]       req_load_op = '0;
    logic [1:0]       req_off = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             data_ok = 1'b0;
    logic [31:0]      data_rdata = '0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_is_store;
    logic             q_full;
    logic             q_empty;
    logic             proto_err;

    int checks = 0;
    int failures = 0;

    mem_resp_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_fire     (req_fire),
        .req_load_op  (req_load_op),
        .req_off      (req_off),
        .req_tag      (req_tag),
        .data_ok      (data_ok),
        .data_rdata   (data_rdata),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_tag      (out_tag),
        .out_is_store (out_is_store),
        .q_full       (q_full),
        .q_empty      (q_empty),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]       op;
        logic [1:0]       off;
        logic [TAG_W-1:0] tag;
        bit               done;
        logic [31:0]      rdata;
    } ent_t;

    ent_t mq[$];
    int   m_discard = 0;
    bit   m_perr = 0;
    int   m_retired = 0;

    function automatic logic [31:0] m_extract(logic [4:0] op, logic [1:0] off, logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = d >> (8 * off);
        h = d >> (16 * off[1]);
        case (op)
            LD_W:    return d;
            LD_B:    return {{24{b[7]}}, b[7:0]};
            LD_BU:   return {24'b0, b[7:0]};
            LD_H:    return {{16{h[15]}}, h[15:0]};
            LD_HU:   return {16'b0, h[15:0]};
            default: return 32'b0;
        endcase
    endfunction

    always @(posedge clk or negedge resetn) begin : model
        int   owed;
        bit   full_pre;
        bit   do_deq;
        bit   found;
        ent_t e;
        if (!resetn) begin
            mq.delete();
            m_discard = 0;
            m_perr = 0;
        end else begin
            full_pre = (mq.size() + m_discard) >= DEPTH;
            if (flush) begin
                owed = m_discard + (req_fire ? 1 : 0);
                foreach (mq[i]) if (!mq[i].done) owed++;
                if (data_ok) begin
                    if (owed > 0) owed--;
                    else m_perr = 1;
                end
                mq.delete();
                m_discard = owed;
            end else begin
                do_deq = mq.size() > 0 && mq[0].done && out_ready;
                if (data_ok) begin
                    if (m_discard > 0) begin
                        m_discard--;
                    end else begin
                        found = 0;
                        for (int i = 0; i < mq.size(); i++) begin
                            if (!found && !mq[i].done) begin
                                e = mq[i];
                                e.done = 1;
                                e.rdata = data_rdata;
                                mq[i] = e;
                                found = 1;
                            end
                        end
                        if (!found) m_perr = 1;
                    end
                end
                if (do_deq) begin
                    void'(mq.pop_front());
                    m_retired++;
                end
                if (req_fire) begin
                    if (full_pre) begin
                        m_perr = 1;
                    end else begin
                        e.op = req_load_op;
                        e.off = req_off;
                        e.tag = req_tag;
                        e.done = 0;
                        e.rdata = '0;
                        mq.push_back(e);
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        bit exp_valid;
        if (resetn) begin
            exp_valid = mq.size() > 0 && mq[0].done;
            check("out_valid", 64'(out_valid), 64'(exp_valid));
            if (exp_valid) begin
                check("out_result", 64'(out_result), 64'(m_extract(mq[0].op, mq[0].off, mq[0].rdata)));
                check("out_tag", 64'(out_tag), 64'(mq[0].tag));
                check("out_is_store", 64'(out_is_store), 64'(mq[0].op == ST));
            end
            check("q_full", 64'(q_full), 64'((mq.size() + m_discard) >= DEPTH));
            check("q_empty", 64'(q_empty), 64'(mq.size() == 0 && m_discard == 0));
            check("proto_err", 64'(proto_err), 64'(m_perr));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic f, input logic [4:0] op, input logic [1:0] off,
                        input logic dok, input logic [31:0] rd, input logic fl, input logic rdy);
        req_fire    = f;
        req_load_op = op;
        req_off     = off;
        req_tag     = {$urandom_range(0, 63), $urandom()};
        data_ok     = dok;
        data_rdata  = rd;
        flush       = fl;
        out_ready   = rdy;
        @(posedge clk);
        #1;
        req_fire = 1'b0;
        data_ok  = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        req_fire  = 1'b0;
        data_ok   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        resetn    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        int issued;
        int responded;
        int base;
        bit f;
        bit d;
        logic [4:0] op;
        logic [1:0] off;
        int r;

        do_reset();
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_q_full", 64'(q_full), 64'd0);
        check("reset_q_empty", 64'(q_empty), 64'd1);
        check("reset_proto_err", 64'(proto_err), 64'd0);

        // Back-to-back loads
        step(1, LD_B, 2'd3, 0, 0, 0, 1);
        step(1, LD_HU, 2'd2, 0, 0, 0, 1);
        step(0, ST, 2'd0, 1, 32'h80FF_0000, 0, 1);
        check("b2b_valid0", 64'(out_valid), 64'd1);
        check("b2b_result0", 64'(out_result), 64'hFFFF_FF80);
        step(0, ST, 2'd0, 1, 32'hBEEF_1234, 0, 1);
        check("b2b_valid1", 64'(out_valid), 64'd1);
        check("b2b_result1", 64'(out_result), 64'h0000_BEEF);
        step(0, ST, 2'd0, 0, 0, 0, 1);
        check("b2b_empty", 64'(q_empty), 64'd1);

        // Fill to DEPTH, then overflow
        do_reset();
        step(1, LD_W, 2'd0, 0, 0, 0, 0);
        step(1, LD_W, 2'd0, 0, 0, 0, 0);
        check("fill_full", 64'(q_full), 64'd1);
        check("fill_perr0", 64'(proto_err), 64'd0);
        step(1, LD_W, 2'd0, 0, 0, 0, 0);
        check("ovf_perr", 64'(proto_err), 64'd1);
        check("ovf_full", 64'(q_full), 64'd1);

        // Flush with two owed plus simultaneous fire
        do_reset();
        step(1, LD_W, 2'd0, 0, 0, 0, 1);
        step(1, LD_W, 2'd0, 0, 0, 0, 1);
        step(1, LD_W, 2'd0, 0, 0, 1, 1);
        check("flush_full", 64'(q_full), 64'd1);
        check("flush_not_empty", 64'(q_empty), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, ST, 2'd0, 1, $urandom(), 0, 1);
            check("flush_discard_no_valid", 64'(out_valid), 64'd0);
        end
        check("flush_drained", 64'(q_empty), 64'd1);
        step(1, LD_W, 2'd0, 0, 0, 0, 0);
        step(0, ST, 2'd0, 1, 32'h1234_5678, 0, 0);
        check("flush_new_valid", 64'(out_valid), 64'd1);
        check("flush_new_result", 64'(out_result), 64'h1234_5678);
        check("flush_perr", 64'(proto_err), 64'd0);

        // Store then load with WB back-pressure
        do_reset();
        step(1, ST, 2'd0, 0, 0, 0, 0);
        step(1, LD_W, 2'd0, 0, 0, 0, 0);
        step(0, ST, 2'd0, 1, 32'hDEAD_0000, 0, 0);
        step(0, ST, 2'd0, 1, 32'hCAFE_F00D, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_is_store", 64'(out_is_store), 64'd1);
            check("hold_result", 64'(out_result), 64'd0);
            step(0, ST, 2'd0, 0, 0, 0, 0);
        end
        step(0, ST, 2'd0, 0, 0, 0, 1);
        check("release_valid", 64'(out_valid), 64'd1);
        check("release_is_store", 64'(out_is_store), 64'd0);
        check("release_result", 64'(out_result), 64'hCAFE_F00D);
        step(0, ST, 2'd0, 0, 0, 0, 1);
        check("release_empty", 64'(q_empty), 64'd1);

        // Asynchronous reset mid-cycle
        do_reset();
        step(1, LD_W, 2'd0, 0, 0, 0, 0);
        step(0, ST, 2'd0, 1, 32'h0BAD_F00D, 0, 0);
        check("pre_async_valid", 64'(out_valid), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_empty", 64'(q_empty), 64'd1);
        check("async_full", 64'(q_full), 64'd0);
        check("async_perr", 64'(proto_err), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step(0, ST, 2'd0, 1, 32'h5555_AAAA, 0, 0);
        check("stray_perr", 64'(proto_err), 64'd1);

        // Wrap-around with random response and ready gaps
        do_reset();
        issued = 0;
        responded = 0;
        base = m_retired;
        for (int cyc = 0; cyc < 400 && (m_retired - base) < 10; cyc++) begin
            d = (issued - responded) > 0 && ($urandom_range(0, 1) == 1);
            f = issued < 10 && !q_full && ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 4);
            op = 5'b00001 << r;
            if (op == LD_W) off = 2'd0;
            else if (op == LD_H || op == LD_HU) off = {1'($urandom_range(0, 1)), 1'b0};
            else off = 2'($urandom_range(0, 3));
            if (f) issued++;
            if (d) responded++;
            step(f, op, off, d, $urandom(), 0, $urandom_range(0, 3) != 0);
        end
        check("wrap_retired", 64'(m_retired - base), 64'd10);
        check("wrap_perr", 64'(proto_err), 64'd0);
        check("wrap_empty", 64'(q_empty), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
